// File: rtl/micro_operations.sv
// rtl/micro_operations.sv - shared micro-operation classes, field layout and condition codes
package micro_operations;

    typedef enum logic [2:0] {
        UOP_NOP       = 3'd0,
        UOP_INTEGER   = 3'd1,
        UOP_INTEGER_M = 3'd2,
        UOP_LOAD      = 3'd3,
        UOP_STORE     = 3'd4
    } uop_class_e;

    // Field order is the uop bit layout, LSB last: cls occupies [2:0].
    typedef struct packed {
        logic [3:0] cond;
        logic       imm;
        logic [3:0] src2;
        logic [3:0] src1;
        logic [3:0] opcode;
        logic       write_cpsr;
        logic       write_dest;
        logic [3:0] dest;
        uop_class_e cls;
    } uop_t;

    localparam int UOP_FIELDS_W = $bits(uop_t);

    localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
                           COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
                           COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
                           COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = !c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = !v;
            COND_HI: cond_pass = c && !z;
            COND_LS: cond_pass = !c || z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = !z && (n == v);
            COND_LE: cond_pass = z || (n != v);
            COND_AL: cond_pass = 1'b1;
            COND_NV: cond_pass = 1'b0;
            default: cond_pass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - circular instruction queue with wrap-bit pointers
module instr_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        push_valid_i,
    input  logic [31:0] push_data_i,
    output logic        push_ready_o,
    input  logic        pop_i,
    output logic        head_valid_o,
    output logic [31:0] head_data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [31:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        full, empty, push, pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = push_valid_i && !full && !flush_i;
    assign pop   = pop_i && !empty;

    assign push_ready_o = !full;
    assign head_valid_o = !empty;
    assign head_data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/instruction_decode_issue.sv
// rtl/instruction_decode_issue.sv - decode queue head, resolve hazards and operands, issue one uop per cycle
module instruction_decode_issue
    import micro_operations::*;
#(
    parameter int DEPTH = 4,
    parameter int NREG  = 16,
    parameter int UOP_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid_i,
    input  logic [31:0]      instr_i,
    output logic             instr_ready_o,
    input  logic             flush_i,
    input  logic [3:0]       cpsr_flags_i,
    output logic [3:0]       rr1_i_o,
    output logic [3:0]       rr2_i_o,
    input  logic [31:0]      rr1_i,
    input  logic [31:0]      rr2_i,
    input  logic             wb_valid_i,
    input  logic [3:0]       wb_dest_i,
    input  logic [31:0]      wb_data_i,
    output logic             uop_valid_o,
    input  logic             uop_ready_i,
    output logic [UOP_W-1:0] uop_o,
    output logic [31:0]      a_o,
    output logic [31:0]      b_o
);

    logic             head_valid;
    logic [31:0]      head;
    uop_t             fields;
    logic             skip, use1, use2, fwd1, fwd2, stall, drop, issue, pop, out_free;
    logic [31:0]      opa, opb;
    logic [NREG-1:0]  sb_q, sb_d;
    logic             uop_valid_q;
    logic [UOP_W-1:0] uop_q;
    logic [31:0]      a_q, b_q;

    instr_queue #(.DEPTH(DEPTH)) u_instr_queue (
        .clk          (clk),
        .rst_n        (rst),
        .flush_i      (flush_i),
        .push_valid_i (instr_valid_i),
        .push_data_i  (instr_i),
        .push_ready_o (instr_ready_o),
        .pop_i        (pop),
        .head_valid_o (head_valid),
        .head_data_o  (head)
    );

    // Class priority: NOP, MUL, DP, LOAD/STORE, otherwise UNDEF.
    always_comb begin
        fields      = '0;
        fields.cond = head[31:28];
        skip        = 1'b0;
        use1        = 1'b0;
        use2        = 1'b0;
        if (head[27:0] == 28'h320F000) begin
            skip = 1'b1;
        end else if (!head[25] && head[7] && head[4]) begin
            fields.cls        = UOP_INTEGER_M;
            fields.dest       = head[19:16];
            fields.write_dest = !head[23];
            fields.write_cpsr = head[20];
            fields.src1       = head[3:0];
            fields.src2       = head[11:8];
            use1              = 1'b1;
            use2              = 1'b1;
        end else if (head[27:26] == 2'b00) begin
            fields.cls        = UOP_INTEGER;
            fields.dest       = head[15:12];
            fields.opcode     = head[24:21];
            fields.write_cpsr = head[20] || (head[24:23] == 2'b10);
            fields.write_dest = (head[24:23] != 2'b10);
            fields.src1       = head[19:16];
            fields.src2       = head[3:0];
            fields.imm        = head[25];
            use1              = 1'b1;
            use2              = !head[25];
        end else if (head[27:25] == 3'b011) begin
            fields.cls        = head[20] ? UOP_LOAD : UOP_STORE;
            fields.dest       = head[15:12];
            fields.opcode     = head[24:21];
            fields.write_dest = head[20];
            fields.src1       = head[19:16];
            fields.imm        = 1'b1;
            use1              = 1'b1;
        end else begin
            skip = 1'b1;
        end
    end

    assign rr1_i_o = head_valid ? fields.src1 : 4'd0;
    assign rr2_i_o = head_valid ? fields.src2 : 4'd0;

    // A writeback landing this cycle is not yet visible in the register file.
    assign fwd1  = wb_valid_i && (wb_dest_i == fields.src1);
    assign fwd2  = wb_valid_i && (wb_dest_i == fields.src2);
    assign opa   = fwd1 ? wb_data_i : rr1_i;
    assign opb   = fields.imm ? {20'd0, head[11:0]} : (fwd2 ? wb_data_i : rr2_i);
    assign stall = (use1 && sb_q[fields.src1] && !fwd1) || (use2 && sb_q[fields.src2] && !fwd2);

    assign out_free = !uop_valid_q || uop_ready_i;
    assign drop     = head_valid && (skip || !cond_pass(fields.cond, cpsr_flags_i));
    assign issue    = head_valid && !drop && !stall && out_free && !flush_i;
    assign pop      = drop || issue;

    always_comb begin
        sb_d = sb_q;
        if (wb_valid_i)                 sb_d[wb_dest_i]   = 1'b0;
        if (issue && fields.write_dest) sb_d[fields.dest] = 1'b1;
        if (flush_i)                    sb_d              = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_q        <= '0;
            uop_valid_q <= 1'b0;
            uop_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            sb_q <= sb_d;
            if (flush_i) begin
                uop_valid_q <= 1'b0;
            end else if (issue) begin
                uop_valid_q <= 1'b1;
                uop_q       <= {{(UOP_W-UOP_FIELDS_W){1'b0}}, fields};
                a_q         <= opa;
                b_q         <= opb;
            end else if (uop_ready_i) begin
                uop_valid_q <= 1'b0;
            end
        end
    end

    assign uop_valid_o = uop_valid_q;
    assign uop_o       = uop_q;
    assign a_o         = a_q;
    assign b_o         = b_q;

endmodule
